// File: rtl/momentum_pkg.sv
// rtl/momentum_pkg.sv - shared slot encoding, state bit indices and field constants
// Imported by the resolver and by the object multiplexer so both agree on slot order.
package momentum_pkg;

  localparam int XW = 11;
  localparam int YW = 10;

  localparam int X_MIN    = 0;
  localparam int X_MAX    = 1279;
  localparam int GROUND_Y = 900;

  localparam int PLAYER_W = 32;
  localparam int PLAYER_H = 48;
  localparam int CANNON_W = 8;
  localparam int CANNON_H = 8;

  localparam int GROUNDED = 0;
  localparam int WALL_L   = 1;
  localparam int WALL_R   = 2;
  localparam int HIT      = 3;

  // Low two bits carry the bus slot code; bit 2 marks the post-reset NONE slot.
  typedef enum logic [2:0] {
    SLOT_P1    = 3'b000,
    SLOT_P2    = 3'b001,
    SLOT_CAN_S = 3'b010,
    SLOT_CAN_E = 3'b011,
    SLOT_NONE  = 3'b100
  } slot_e;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } pos_t;

  // Sums are one bit wider than the coordinates, so they never wrap.
  function automatic logic [3:0] boundary_bits(
    input logic [XW-1:0] x,
    input logic [YW-1:0] y,
    input int            w,
    input int            h
  );
    logic [XW:0] x_end;
    logic [YW:0] y_end;
    logic [3:0]  bits;
    x_end          = {1'b0, x} + (XW+1)'(w);
    y_end          = {1'b0, y} + (YW+1)'(h);
    bits           = '0;
    bits[GROUNDED] = (y_end >= (YW+1)'(GROUND_Y));
    bits[WALL_L]   = (x <= XW'(X_MIN));
    bits[WALL_R]   = (x_end >= (XW+1)'(X_MAX));
    return bits;
  endfunction

endpackage

// File: rtl/momentum_resolver_aabb_overlap.sv
// rtl/momentum_resolver_aabb_overlap.sv - strict axis-aligned box overlap test
// Box A at (a_x, a_y) of size AW x AH against box B at (b_x, b_y) of size BW x BH.
module aabb_overlap #(
  parameter int XW = 11,
  parameter int YW = 10,
  parameter int AW = 8,
  parameter int AH = 8,
  parameter int BW = 32,
  parameter int BH = 48
) (
  input  logic [XW-1:0] a_x_i,
  input  logic [YW-1:0] a_y_i,
  input  logic [XW-1:0] b_x_i,
  input  logic [YW-1:0] b_y_i,
  output logic          overlap_o
);

  logic [XW:0] a_x_e, b_x_e, a_x_end, b_x_end;
  logic [YW:0] a_y_e, b_y_e, a_y_end, b_y_end;

  assign a_x_e   = {1'b0, a_x_i};
  assign b_x_e   = {1'b0, b_x_i};
  assign a_y_e   = {1'b0, a_y_i};
  assign b_y_e   = {1'b0, b_y_i};
  assign a_x_end = a_x_e + (XW+1)'(AW);
  assign b_x_end = b_x_e + (XW+1)'(BW);
  assign a_y_end = a_y_e + (YW+1)'(AH);
  assign b_y_end = b_y_e + (YW+1)'(BH);

  // Touching edges do not count as overlap.
  assign overlap_o = (a_x_e < b_x_end) && (b_x_e < a_x_end) &&
                     (a_y_e < b_y_end) && (b_y_e < a_y_end);

endmodule

// File: rtl/momentum_resolver.sv
// rtl/momentum_resolver.sv - per-slot boundary and cannon-hit classifier for the object bus
// Result for the object on the bus in cycle k is registered and visible in cycle k+1.
module momentum_resolver
  import momentum_pkg::*;
(
  input  logic          clk_slow,
  input  logic          rst_n,
  input  logic [XW-1:0] object_x,
  input  logic [YW-1:0] object_y,
  output logic [3:0]    object_state
);

  slot_e      slot_q, slot_d;
  logic [3:0] state_q, state_d;
  pos_t       p1_pos_q, p1_pos_d, p2_pos_q, p2_pos_d;
  logic       p1_vld_q, p1_vld_d, p2_vld_q, p2_vld_d;
  logic       hit_p1_q, hit_p1_d, hit_p2_q, hit_p2_d;
  logic       can_hit_q, can_hit_d;

  logic       ov_p1_raw, ov_p2_raw;
  logic       ov_p1, ov_p2, cannon_present, can_hit_now;
  logic       set_p1, set_p2, rep_p1, rep_p2;
  logic [3:0] bnd_player, bnd_cannon;

  aabb_overlap #(
    .XW(XW), .YW(YW),
    .AW(CANNON_W), .AH(CANNON_H),
    .BW(PLAYER_W), .BH(PLAYER_H)
  ) u_ov_p1 (
    .a_x_i     (object_x),
    .a_y_i     (object_y),
    .b_x_i     (p1_pos_q.x),
    .b_y_i     (p1_pos_q.y),
    .overlap_o (ov_p1_raw)
  );

  aabb_overlap #(
    .XW(XW), .YW(YW),
    .AW(CANNON_W), .AH(CANNON_H),
    .BW(PLAYER_W), .BH(PLAYER_H)
  ) u_ov_p2 (
    .a_x_i     (object_x),
    .a_y_i     (object_y),
    .b_x_i     (p2_pos_q.x),
    .b_y_i     (p2_pos_q.y),
    .overlap_o (ov_p2_raw)
  );

  assign cannon_present = (object_x < XW'(X_MAX));
  assign ov_p1          = ov_p1_raw & p1_vld_q;
  assign ov_p2          = ov_p2_raw & p2_vld_q;
  assign can_hit_now    = cannon_present & (ov_p1 | ov_p2);
  assign bnd_player     = boundary_bits(object_x, object_y, PLAYER_W, PLAYER_H);
  assign bnd_cannon     = boundary_bits(object_x, object_y, CANNON_W, CANNON_H);

  always_ff @(posedge clk_slow or negedge rst_n) begin
    if (!rst_n) begin
      slot_q    <= SLOT_NONE;
      state_q   <= '0;
      p1_pos_q  <= '0;
      p2_pos_q  <= '0;
      p1_vld_q  <= 1'b0;
      p2_vld_q  <= 1'b0;
      hit_p1_q  <= 1'b0;
      hit_p2_q  <= 1'b0;
      can_hit_q <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      state_q   <= state_d;
      p1_pos_q  <= p1_pos_d;
      p2_pos_q  <= p2_pos_d;
      p1_vld_q  <= p1_vld_d;
      p2_vld_q  <= p2_vld_d;
      hit_p1_q  <= hit_p1_d;
      hit_p2_q  <= hit_p2_d;
      can_hit_q <= can_hit_d;
    end
  end

  always_comb begin
    slot_d = SLOT_NONE;
    unique case (slot_q)
      SLOT_NONE:  slot_d = SLOT_P1;
      SLOT_P1:    slot_d = SLOT_P2;
      SLOT_P2:    slot_d = SLOT_CAN_S;
      SLOT_CAN_S: slot_d = SLOT_CAN_E;
      SLOT_CAN_E: slot_d = SLOT_P1;
      default:    slot_d = SLOT_NONE;
    endcase
  end

  always_comb begin
    state_d   = '0;
    p1_pos_d  = p1_pos_q;
    p2_pos_d  = p2_pos_q;
    p1_vld_d  = p1_vld_q;
    p2_vld_d  = p2_vld_q;
    can_hit_d = can_hit_q;
    set_p1    = 1'b0;
    set_p2    = 1'b0;
    rep_p1    = 1'b0;
    rep_p2    = 1'b0;
    unique case (slot_q)
      SLOT_P1: begin
        state_d      = bnd_player;
        state_d[HIT] = hit_p1_q;
        rep_p1       = 1'b1;
        p1_pos_d     = '{x: object_x, y: object_y};
        p1_vld_d     = 1'b1;
      end
      SLOT_P2: begin
        state_d      = bnd_player;
        state_d[HIT] = hit_p2_q;
        rep_p2       = 1'b1;
        p2_pos_d     = '{x: object_x, y: object_y};
        p2_vld_d     = 1'b1;
      end
      SLOT_CAN_S: begin
        can_hit_d = can_hit_now;
        if (cannon_present) begin
          state_d      = bnd_cannon;
          state_d[HIT] = can_hit_now;
          set_p1       = ov_p1;
          set_p2       = ov_p2;
        end
      end
      SLOT_CAN_E: begin
        if (cannon_present) begin
          state_d      = bnd_cannon;
          state_d[HIT] = can_hit_q;
        end
      end
      default: state_d = '0;
    endcase
    // A new hit outranks the clear that comes with reporting.
    hit_p1_d = set_p1 | (hit_p1_q & ~rep_p1);
    hit_p2_d = set_p2 | (hit_p2_q & ~rep_p2);
  end

  assign object_state = state_q;

endmodule
